// File: rtl/priority_irq_controller.sv
// priority_irq_controller: 8-line pending register, highest-index-first selection, valid/ack handshake.
// Define IRQ_MASK_EN to add a per-line selection mask input (mask, 1 = line eligible).
module priority_irq_controller #(
    parameter int EDGE_MODE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
`ifdef IRQ_MASK_EN
    input  logic [7:0] mask,
`endif
    input  logic       irq_ack,
    input  logic       clr_overrun,
    output logic       irq_valid,
    output logic [2:0] irq_id,
    output logic [7:0] pending,
    output logic [7:0] overrun
);
    typedef enum logic {IDLE, PRESENT} state_t;
    state_t     state_q, state_d;
    logic [7:0] req_q;
    logic [7:0] pending_q, pending_d;
    logic [7:0] overrun_q, overrun_d;
    logic [2:0] irq_id_q, irq_id_d;
    logic [7:0] rise, clr, eligible;
    logic [2:0] top_id;
`ifdef IRQ_MASK_EN
    assign eligible = pending_q & mask;
`else
    assign eligible = pending_q;
`endif
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            req_q     <= 8'hFF;
            pending_q <= 8'h00;
            overrun_q <= 8'h00;
            irq_id_q  <= 3'd0;
        end else begin
            state_q   <= state_d;
            req_q     <= req;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            irq_id_q  <= irq_id_d;
        end
    end
    always_comb begin
        top_id = 3'd0;
        for (int i = 0; i < 8; i++)
            if (eligible[i]) top_id = 3'(i);
    end
    // A new request on a bit being cleared by ack keeps it pending (set wins).
    always_comb begin
        rise      = (EDGE_MODE != 0) ? (req & ~req_q) : req;
        clr       = (state_q == PRESENT && irq_ack) ? (8'b1 << irq_id_q) : 8'h00;
        pending_d = (pending_q & ~clr) | rise;
        overrun_d = (clr_overrun ? 8'h00 : overrun_q) | (rise & pending_q & ~clr);
    end
    always_comb begin
        state_d  = (state_q == IDLE) ? ((|eligible) ? PRESENT : IDLE) : (irq_ack ? IDLE : PRESENT);
        irq_id_d = (state_q == IDLE && |eligible) ? top_id : irq_id_q;
    end
    always_comb begin
        irq_valid = (state_q == PRESENT);
        irq_id    = irq_id_q;
        pending   = pending_q;
        overrun   = overrun_q;
    end
endmodule

// File: tb/tb_priority_irq_controller.sv
// tb_priority_irq_controller: directed scenarios plus randomized traffic against a bit-level reference model,
// on one edge-mode and one level-mode instance sharing inputs.
module tb_priority_irq_controller;
    logic       clk = 0;
    logic       rst_n = 0;
    logic [7:0] req = 0;
    logic       irq_ack = 0;
    logic       clr_overrun = 0;
    logic [7:0] mask = 8'hFF;
    logic       e_valid, l_valid;
    logic [2:0] e_id, l_id;
    logic [7:0] e_pend, l_pend, e_ovr, l_ovr;
    int checks = 0;
    int passed = 0;
    bit [7:0] m_pend [2];
    bit [7:0] m_ovr  [2];
    bit [7:0] m_prev [2];
    bit       m_valid[2];
    bit [2:0] m_id   [2];

    always #5 clk = ~clk;

    priority_irq_controller #(.EDGE_MODE(1)) u_e (
        .clk(clk), .rst_n(rst_n), .req(req),
`ifdef IRQ_MASK_EN
        .mask(mask),
`endif
        .irq_ack(irq_ack), .clr_overrun(clr_overrun),
        .irq_valid(e_valid), .irq_id(e_id), .pending(e_pend), .overrun(e_ovr)
    );
    priority_irq_controller #(.EDGE_MODE(0)) u_l (
        .clk(clk), .rst_n(rst_n), .req(req),
`ifdef IRQ_MASK_EN
        .mask(mask),
`endif
        .irq_ack(irq_ack), .clr_overrun(clr_overrun),
        .irq_valid(l_valid), .irq_id(l_id), .pending(l_pend), .overrun(l_ovr)
    );

    // Advance one clock edge, update the reference model from the inputs seen at that edge, sample at negedge.
    task automatic step();
        bit [7:0] ev, np, no;
        bit       served;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_pend[k] = 0; m_ovr[k] = 0; m_valid[k] = 0; m_id[k] = 0; m_prev[k] = 8'hFF;
            end else begin
                ev = (k == 0) ? (req & ~m_prev[k]) : req;
                np = 0;
                no = clr_overrun ? 8'h00 : m_ovr[k];
                for (int i = 0; i < 8; i++) begin
                    served = m_valid[k] && irq_ack && (m_id[k] == 3'(i));
                    if (ev[i] || (m_pend[k][i] && !served)) np[i] = 1;
                    if (ev[i] && m_pend[k][i] && !served) no[i] = 1;
                end
                if (m_valid[k]) begin
                    if (irq_ack) m_valid[k] = 0;
                end else begin
                    for (int i = 0; i < 8; i++)
                        if (m_pend[k][i] && mask[i]) begin
                            m_valid[k] = 1;
                            m_id[k] = 3'(i);
                        end
                end
                m_pend[k] = np; m_ovr[k] = no; m_prev[k] = req;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        req = 8'h81; rst_n = 0;
        step(); step();
        checks++; if (e_pend !== 8'h00 || e_ovr !== 8'h00) $display("FAIL reset_regs: got pend=%h ovr=%h want 00/00", e_pend, e_ovr); else passed++;
        checks++; if (e_valid !== 1'b0 || e_id !== 3'd0) $display("FAIL reset_out: got valid=%b id=%0d want 0/0", e_valid, e_id); else passed++;
        checks++; if (l_valid !== 1'b0 || l_pend !== 8'h00) $display("FAIL reset_lvl: got valid=%b pend=%h want 0/00", l_valid, l_pend); else passed++;
        rst_n = 1;
        step();
        checks++; if (l_pend !== 8'h81) $display("FAIL reset_lvl_pend: got %h want 81", l_pend); else passed++;
        step(); step();
        checks++; if (e_pend !== 8'h00 || e_valid !== 1'b0) $display("FAIL reset_held_high: got pend=%h valid=%b want 00/0", e_pend, e_valid); else passed++;
    endtask

    task automatic test_basic();
        req = 8'h00; step();
        req = 8'h08; step();
        checks++; if (e_pend !== 8'h08 || e_valid !== 1'b0) $display("FAIL basic_latch: got pend=%h valid=%b want 08/0", e_pend, e_valid); else passed++;
        step();
        checks++; if (e_valid !== 1'b1 || e_id !== 3'd3) $display("FAIL basic_present: got valid=%b id=%0d want 1/3", e_valid, e_id); else passed++;
        irq_ack = 1; step(); irq_ack = 0; req = 8'h00;
        checks++; if (e_pend !== 8'h00 || e_valid !== 1'b0) $display("FAIL basic_ack: got pend=%h valid=%b want 00/0", e_pend, e_valid); else passed++;
    endtask

    task automatic test_priority();
        req = 8'h42; step(); req = 8'h00; step();
        checks++; if (e_valid !== 1'b1 || e_id !== 3'd6) $display("FAIL prio_first: got valid=%b id=%0d want 1/6", e_valid, e_id); else passed++;
        irq_ack = 1; step(); irq_ack = 0;
        checks++; if (e_pend !== 8'h02 || e_valid !== 1'b0) $display("FAIL prio_gap: got pend=%h valid=%b want 02/0", e_pend, e_valid); else passed++;
        step();
        checks++; if (e_valid !== 1'b1 || e_id !== 3'd1) $display("FAIL prio_second: got valid=%b id=%0d want 1/1", e_valid, e_id); else passed++;
        irq_ack = 1; step(); irq_ack = 0;
        checks++; if (e_pend !== 8'h00 || e_valid !== 1'b0) $display("FAIL prio_drain: got pend=%h valid=%b want 00/0", e_pend, e_valid); else passed++;
    endtask

    task automatic test_hold();
        req = 8'h04; step(); req = 8'h00; step();
        req = 8'h80; step(); req = 8'h00; step();
        checks++; if (e_valid !== 1'b1 || e_id !== 3'd2 || e_pend !== 8'h84) $display("FAIL hold_id: got valid=%b id=%0d pend=%h want 1/2/84", e_valid, e_id, e_pend); else passed++;
        irq_ack = 1; step(); irq_ack = 0; step();
        checks++; if (e_valid !== 1'b1 || e_id !== 3'd7) $display("FAIL hold_next: got valid=%b id=%0d want 1/7", e_valid, e_id); else passed++;
        irq_ack = 1; step(); irq_ack = 0;
    endtask

    task automatic test_overrun();
        req = 8'h10; step(); req = 8'h00; step();
        req = 8'h10; step(); req = 8'h00;
        checks++; if (e_ovr !== 8'h10 || e_pend !== 8'h10) $display("FAIL ovr_set: got ovr=%h pend=%h want 10/10", e_ovr, e_pend); else passed++;
        clr_overrun = 1; step(); clr_overrun = 0;
        checks++; if (e_ovr !== 8'h00) $display("FAIL ovr_clear: got %h want 00", e_ovr); else passed++;
        irq_ack = 1; req = 8'h10; step(); irq_ack = 0; req = 8'h00;
        checks++; if (e_pend !== 8'h10 || e_ovr !== 8'h00 || e_valid !== 1'b0) $display("FAIL ack_rise_same: got pend=%h ovr=%h valid=%b want 10/00/0", e_pend, e_ovr, e_valid); else passed++;
        step();
        checks++; if (e_valid !== 1'b1 || e_id !== 3'd4) $display("FAIL ack_rise_repend: got valid=%b id=%0d want 1/4", e_valid, e_id); else passed++;
        irq_ack = 1; step(); irq_ack = 0;
    endtask

    task automatic test_level();
        rst_n = 0; req = 8'h00; step(); rst_n = 1; step();
        req = 8'h20; step(); step();
        checks++; if (l_valid !== 1'b1 || l_id !== 3'd5) $display("FAIL lvl_present: got valid=%b id=%0d want 1/5", l_valid, l_id); else passed++;
        irq_ack = 1; step(); irq_ack = 0;
        checks++; if (l_pend[5] !== 1'b1 || l_valid !== 1'b0) $display("FAIL lvl_repend: got pend=%h valid=%b want bit5 set/0", l_pend, l_valid); else passed++;
        step();
        checks++; if (l_valid !== 1'b1 || l_id !== 3'd5) $display("FAIL lvl_again: got valid=%b id=%0d want 1/5", l_valid, l_id); else passed++;
        rst_n = 0; step();
        checks++; if ({l_valid, l_id, l_pend, l_ovr} !== 20'h0 || {e_valid, e_id, e_pend, e_ovr} !== 20'h0) $display("FAIL reset_mid: got lvl=%h edge=%h want 0/0", {l_valid, l_id, l_pend, l_ovr}, {e_valid, e_id, e_pend, e_ovr}); else passed++;
        rst_n = 1; req = 8'h00; step();
    endtask

`ifdef IRQ_MASK_EN
    task automatic test_mask();
        mask = 8'h7F; req = 8'h81; step(); req = 8'h00; step();
        checks++; if (e_valid !== 1'b1 || e_id !== 3'd0) $display("FAIL mask_low: got valid=%b id=%0d want 1/0", e_valid, e_id); else passed++;
        irq_ack = 1; step(); irq_ack = 0; mask = 8'hFF; step();
        checks++; if (e_valid !== 1'b1 || e_id !== 3'd7) $display("FAIL mask_open: got valid=%b id=%0d want 1/7", e_valid, e_id); else passed++;
        irq_ack = 1; step(); irq_ack = 0;
        mask = 8'h00; req = 8'h01; step(); req = 8'h00; step(); step();
        checks++; if (e_valid !== 1'b0 || e_pend !== 8'h01) $display("FAIL mask_all: got valid=%b pend=%h want 0/01", e_valid, e_pend); else passed++;
        mask = 8'hFF; step();
        checks++; if (e_valid !== 1'b1 || e_id !== 3'd0) $display("FAIL mask_release: got valid=%b id=%0d want 1/0", e_valid, e_id); else passed++;
        irq_ack = 1; step(); irq_ack = 0;
    endtask
`endif

    task automatic test_random();
        for (int n = 0; n < 1500; n++) begin
            rst_n       = ($urandom_range(0, 99) != 0);
            req         = 8'($urandom & $urandom & $urandom);
            irq_ack     = 1'($urandom_range(0, 1));
            clr_overrun = ($urandom_range(0, 7) == 0);
`ifdef IRQ_MASK_EN
            mask        = 8'($urandom | $urandom);
`endif
            step();
            checks++; if (e_valid !== m_valid[0] || (m_valid[0] && e_id !== m_id[0])) $display("FAIL rnd_edge_out n=%0d: got %b/%0d want %b/%0d", n, e_valid, e_id, m_valid[0], m_id[0]); else passed++;
            checks++; if (e_pend !== m_pend[0] || e_ovr !== m_ovr[0]) $display("FAIL rnd_edge_regs n=%0d: got %h/%h want %h/%h", n, e_pend, e_ovr, m_pend[0], m_ovr[0]); else passed++;
            checks++; if (l_valid !== m_valid[1] || (m_valid[1] && l_id !== m_id[1])) $display("FAIL rnd_lvl_out n=%0d: got %b/%0d want %b/%0d", n, l_valid, l_id, m_valid[1], m_id[1]); else passed++;
            checks++; if (l_pend !== m_pend[1] || l_ovr !== m_ovr[1]) $display("FAIL rnd_lvl_regs n=%0d: got %h/%h want %h/%h", n, l_pend, l_ovr, m_pend[1], m_ovr[1]); else passed++;
        end
        rst_n = 1; irq_ack = 0; clr_overrun = 0; req = 8'h00; mask = 8'hFF;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_priority();
        test_hold();
        test_overrun();
        test_level();
`ifdef IRQ_MASK_EN
        test_mask();
`endif
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
